// File: rtl/ram_burst_loader.sv
// ram_burst_loader: latches a source word and streams n of its bytes
// (n = min(2^wr, DW/8)) to a byte-wide memory port, one byte per accepted
// write, at incrementing (wrapping) byte addresses.
//
// Optional feature: define RAMLD_BIGEND_EN to add input `be`, latched at
// start; be=1 emits the selected n-byte field most-significant byte first.
//
// state | meaning
// IDLE  | waiting for start; we=0, adq/q hold the last values
// LOAD  | burst in progress; we=1 until the last byte is accepted
module ram_burst_loader #(
    parameter int DW = 64,
    parameter int AW = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [1:0]    wr,
    input  logic [AW-1:0] add,
    input  logic [DW-1:0] d,
    input  logic          mem_rdy,
`ifdef RAMLD_BIGEND_EN
    input  logic          be,
`endif
    output logic          kp,
    output logic          we,
    output logic [AW-1:0] adq,
    output logic [7:0]    q,
    output logic          done
);

    localparam int NB = DW / 8;

    typedef enum logic {IDLE, LOAD} state_t;

    state_t        state_q, state_d;
    logic [DW-1:0] data_q, data_d;
    logic [3:0]    cnt_q, cnt_d;
    logic [2:0]    idx_q, idx_d;
    logic          be_q, be_d;
    logic          kp_q, kp_d;
    logic          we_q, we_d;
    logic [AW-1:0] adq_q, adq_d;
    logic [7:0]    q_q, q_d;
    logic          done_q, done_d;

    logic          be_in;
    logic [3:0]    n_new;
    logic          last;

`ifdef RAMLD_BIGEND_EN
    assign be_in = be;
`else
    assign be_in = 1'b0;
`endif

    // Burst length in bytes, clipped to the source word width.
    function automatic logic [3:0] byte_count(input logic [1:0] code);
        logic [3:0] n;
        n = 4'd1 << code;
        if (n > 4'(NB)) n = 4'(NB);
        return n;
    endfunction

    // Byte k of the burst; big-endian order counts down from the top of the n-byte field.
    function automatic logic [7:0] pick(input logic [DW-1:0] word, input logic [2:0] k,
                                        input logic [3:0] n, input logic big);
        logic [2:0]    sel;
        logic [DW-1:0] sh;
        sel = big ? 3'(n - 4'd1 - {1'b0, k}) : k;
        sh  = word >> {sel, 3'b000};
        return sh[7:0];
    endfunction

    assign last = ({1'b0, idx_q} == (cnt_q - 4'd1));

    // Next-state and next-output computation.
    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        be_d    = be_q;
        kp_d    = kp_q;
        we_d    = we_q;
        adq_d   = adq_q;
        q_d     = q_q;
        done_d  = 1'b0;
        n_new   = byte_count(wr);
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = LOAD;
                    data_d  = d;
                    cnt_d   = n_new;
                    idx_d   = 3'd0;
                    be_d    = be_in;
                    kp_d    = 1'b1;
                    we_d    = 1'b1;
                    adq_d   = add;
                    q_d     = pick(d, 3'd0, n_new, be_in);
                end
            end
            LOAD: begin
                if (we_q && mem_rdy) begin
                    if (last) begin
                        state_d = IDLE;
                        kp_d    = 1'b0;
                        we_d    = 1'b0;
                        done_d  = 1'b1;
                    end else begin
                        idx_d = idx_q + 3'd1;
                        adq_d = adq_q + AW'(1);
                        q_d   = pick(data_q, idx_q + 3'd1, cnt_q, be_q);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            data_q  <= '0;
            cnt_q   <= '0;
            idx_q   <= '0;
            be_q    <= 1'b0;
            kp_q    <= 1'b0;
            we_q    <= 1'b0;
            adq_q   <= '0;
            q_q     <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            be_q    <= be_d;
            kp_q    <= kp_d;
            we_q    <= we_d;
            adq_q   <= adq_d;
            q_q     <= q_d;
            done_q  <= done_d;
        end
    end

    assign kp   = kp_q;
    assign we   = we_q;
    assign adq  = adq_q;
    assign q    = q_q;
    assign done = done_q;

endmodule
